logic16_unit: RTL and testbench



---
 rtl/logic16_pkg.sv | 34 +++
 rtl/logic16_fifo.sv | 71 +++++++
 rtl/logic16_unit.sv | 83 ++++++++
 tb/tb_logic16_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/logic16_pkg.sv
// Shared types and the bitwise evaluation function for logic16_unit.
package logic16_pkg;

  localparam int LOGIC16_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } logic16_op_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } logic16_occ_t;

  function automatic logic [LOGIC16_WIDTH-1:0] logic16_eval(
    input logic16_op_t              op,
    input logic [LOGIC16_WIDTH-1:0] a,
    input logic [LOGIC16_WIDTH-1:0] b
  );
    logic [LOGIC16_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic16_fifo.sv
// Synchronous FIFO with registered occupancy count; outputs depend only on state.
module logic16_fifo
  import logic16_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic16_occ_t            occ;
  logic                    do_push, do_pop;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)
      occ = OCC_EMPTY;
    else if (count_q == CW'(DEPTH))
      occ = OCC_FULL;
  end

  assign full_o  = (occ == OCC_FULL);
  assign empty_o = (occ == OCC_EMPTY);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !reset)
      mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/logic16_unit.sv
// Handshaked bitwise logic unit with result FIFO and pop counter.
// Optional LOGIC16_ZERO_FLAG_EN adds a stored per-entry zero flag and the out_zero port.
module logic16_unit
  import logic16_pkg::*;
#(
  parameter int WIDTH = LOGIC16_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef LOGIC16_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic [15:0]      txn_count
);

`ifdef LOGIC16_ZERO_FLAG_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  logic [WIDTH-1:0] res;
  logic [EW-1:0]    wdata, rdata;
  logic             full, empty, push, pop;
  logic [15:0]      txn_q, txn_d;

  generate
    if (WIDTH == LOGIC16_WIDTH) begin : g_pkg_eval
      assign res = logic16_eval(logic16_op_t'(in_op), in_a, in_b);
    end else begin : g_wide_eval
      always_comb begin
        case (logic16_op_t'(in_op))
          OP_AND:  res = in_a & in_b;
          OP_OR:   res = in_a | in_b;
          OP_XOR:  res = in_a ^ in_b;
          default: res = ~(in_a & in_b);
        endcase
      end
    end
  endgenerate

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef LOGIC16_ZERO_FLAG_EN
  assign wdata    = {(res == '0), res};
  assign out_zero = rdata[WIDTH] && !empty;
`else
  assign wdata    = res;
`endif
  assign out_data = rdata[WIDTH-1:0];

  logic16_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign txn_d     = pop ? txn_q + 16'd1 : txn_q;
  assign txn_count = txn_q;

  always_ff @(posedge clk) begin
    if (reset) txn_q <= '0;
    else       txn_q <= txn_d;
  end

endmodule

// File: tb/tb_logic16_unit.sv
// Directed self-checking bench for logic16_unit (handles both zero-flag builds).
module tb_logic16_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [15:0] txn_count;
`ifdef LOGIC16_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic16_unit #(.WIDTH(16), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LOGIC16_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .txn_count (txn_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Step past the next rising edge; outputs are sampled and inputs changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
  endtask

  logic [15:0] exp_all [4] = '{16'h1034, 16'h9A76, 16'h8A42, 16'hEFCB};
  int bad;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #2;

    // Reset state and single AND with first-cycle acceptance.
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_txn", txn_count, 0);
`ifdef LOGIC16_ZERO_FLAG_EN
    check("rst_zero", out_zero, 0);
`endif
    req(2'd0, 16'h3CC3, 16'h0FF0); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("and_valid", out_valid, 1);
    check("and_data", out_data, 16'h0CC0);
    check("and_txn_pre", txn_count, 0);
    tick();
    check("and_txn", txn_count, 1);
    check("and_empty", out_valid, 0);

    // All four ops streamed back to back.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req(i[1:0], 16'h1234, 16'h9876);
      tick();
      check($sformatf("stream_ready%0d", i), in_ready, 1);
      check($sformatf("stream_valid%0d", i), out_valid, 1);
      check($sformatf("stream_data%0d", i), out_data, exp_all[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream_txn", txn_count, 4);
    check("stream_drained", out_valid, 0);

    // Backpressure: fill, hold a third request, then drain in order.
    do_reset();
    req(2'd0, 16'hFFFF, 16'hFFFF);
    tick();
    check("bp_ready1", in_ready, 1);
    check("bp_valid1", out_valid, 1);
    req(2'd0, 16'hAAAA, 16'h5555);
    tick();
    check("bp_full", in_ready, 0);
    req(2'd1, 16'h1200, 16'h0034);
    tick();
    tick();
    check("bp_full_hold", in_ready, 0);
    check("bp_head_hold", out_data, 16'hFFFF);
    out_ready = 1'b1;
    check("bp_no_passthru", in_ready, 0);
    tick();
    check("bp_pop1", out_data, 16'h0000);
    check("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_pop3_valid", out_valid, 1);
    check("bp_pop3", out_data, 16'h1234);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_txn", txn_count, 3);

`ifdef LOGIC16_ZERO_FLAG_EN
    // Stored zero flag follows the head entry.
    do_reset();
    req(2'd0, 16'hAAAA, 16'h5555);
    tick();
    check("zf_set", out_zero, 1);
    check("zf_data", out_data, 16'h0000);
    req(2'd2, 16'hFFFF, 16'h0000); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zf_clear", out_zero, 0);
    check("zf_xor_data", out_data, 16'hFFFF);
    tick();
    check("zf_empty", out_zero, 0);
`endif

    // Reset while two results are queued discards them.
    do_reset();
    req(2'd1, 16'h1111, 16'h0000);
    tick();
    req(2'd1, 16'h2222, 16'h0000);
    tick();
    in_valid = 1'b0;
    check("mid_full", in_ready, 0);
    reset = 1'b1;
    tick();
    check("mid_valid", out_valid, 0);
    check("mid_ready", in_ready, 1);
    check("mid_txn", txn_count, 0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("mid_no_emit", out_valid, 0);
    check("mid_txn_after", txn_count, 0);

    // Counter wrap after 65536 NAND(0,0) results.
    do_reset();
    out_ready = 1'b1;
    req(2'd3, 16'h0000, 16'h0000);
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (!(out_valid === 1'b1 && out_data === 16'hFFFF)) bad++;
    end
    in_valid = 1'b0;
    check("wrap_data", bad, 0);
    check("wrap_pre", txn_count, 16'hFFFF);
    tick();
    check("wrap_txn", txn_count, 16'h0000);
    check("wrap_drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
